// File: rtl/sd_spi_responder_if.sv
// Card-side SD SPI-mode signal bundle: command/response lines plus the local read port.
// The responder takes the slave view; the host or bench takes the master view.
interface sd_spi_responder_if;
  logic        cmd_in;
  logic        rsp_out;
  logic        rsp_oe;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport slave (
    input  cmd_in, rd_valid, rd_data,
    output rsp_out, rsp_oe, cmd_valid, cmd_index, cmd_arg, busy, rd_req, rd_addr
  );

  modport master (
    output cmd_in, rd_valid, rd_data,
    input  rsp_out, rsp_oe, cmd_valid, cmd_index, cmd_arg, busy, rd_req, rd_addr
  );
endinterface

// File: rtl/sd_spi_responder.sv
// Bit-serial SD SPI-mode command responder: receives 48-bit frames, answers R1,
// and serves READ_SINGLE_BLOCK as a 0xFE token followed by one 32-bit word.
//
// state     | meaning
// IDLE      | waiting for a start bit on cmd_in
// RX_CMD    | shifting in the remaining 47 frame bits
// NCR       | driving 0xFF filler bytes before R1
// TX_R1     | shifting out the R1 byte
// WAIT_DATA | read requested, driving 1s until rd_valid
// TX_TOKEN  | shifting out the 0xFE data token
// TX_DATA   | shifting out the captured read word
module sd_spi_responder #(
  parameter bit LSB_FIRST = 1'b0,
  parameter int NCR_BYTES = 1
) (
  input  logic              clk,
  input  logic              reset,
  sd_spi_responder_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RX_CMD    = 3'd1;
  localparam logic [2:0] NCR       = 3'd2;
  localparam logic [2:0] TX_R1     = 3'd3;
  localparam logic [2:0] WAIT_DATA = 3'd4;
  localparam logic [2:0] TX_TOKEN  = 3'd5;
  localparam logic [2:0] TX_DATA   = 3'd6;

  localparam logic [5:0] NCR_TC = 6'(8 * NCR_BYTES - 1);

  logic [2:0]  state;
  logic [5:0]  cnt;
  logic [45:0] rx_sr;
  logic [39:0] tx_sr;
  logic        idle_flag;
  logic        app_flag;
  logic        rd_pend;
  logic        cmd_valid_q;
  logic [5:0]  cmd_index_q;
  logic [31:0] cmd_arg_q;
  logic        rd_req_q;

  logic [46:0] tail;
  logic [5:0]  rx_idx;
  logic [31:0] rx_arg;
  logic [6:0]  rx_crc;
  logic        frame_ok;
  logic        crc_err;
  logic        legal;
  logic        idle_new;
  logic        app_new;
  logic [7:0]  r1;
  logic        read_go;
  logic [39:0] r1_load;
  logic [39:0] data_load;
  logic [39:0] tx_next;
  logic        tx_bit;

  // Fields arrive in wire order; with LSB_FIRST each field is bit-reversed on extraction.
  always_comb begin
    tail = {rx_sr, bus.cmd_in};
    rx_idx = '0;
    rx_arg = '0;
    rx_crc = '0;
    for (int i = 0; i < 6; i++)
      rx_idx[i] = LSB_FIRST ? tail[45 - i] : tail[40 + i];
    for (int i = 0; i < 32; i++)
      rx_arg[i] = LSB_FIRST ? tail[39 - i] : tail[8 + i];
    for (int i = 0; i < 7; i++)
      rx_crc[i] = LSB_FIRST ? tail[7 - i] : tail[1 + i];
  end

  // CMD17 is only legal once the card has left the idle state.
  always_comb begin
    frame_ok = tail[46] & tail[0];
    crc_err  = ((rx_idx == 6'd0) && (rx_crc != 7'h4A)) ||
               ((rx_idx == 6'd8) && (rx_crc != 7'h43));
    legal    = (rx_idx == 6'd0) || (rx_idx == 6'd1) || (rx_idx == 6'd8) ||
               (rx_idx == 6'd55) || ((rx_idx == 6'd17) && !idle_flag) ||
               ((rx_idx == 6'd41) && app_flag);
    idle_new = idle_flag;
    app_new  = app_flag;
    if (!crc_err) begin
      app_new = (rx_idx == 6'd55);
      if (rx_idx == 6'd0)
        idle_new = 1'b1;
      else if ((rx_idx == 6'd1) || ((rx_idx == 6'd41) && app_flag))
        idle_new = 1'b0;
    end
    r1        = {4'b0000, crc_err, !legal, 1'b0, idle_new};
    read_go   = (rx_idx == 6'd17) && !idle_new && (r1 == 8'h00);
    r1_load   = LSB_FIRST ? {32'h0, r1} : {r1, 32'h0};
    data_load = LSB_FIRST ? {bus.rd_data, 8'hFE} : {8'hFE, bus.rd_data};
    tx_next   = LSB_FIRST ? {1'b0, tx_sr[39:1]} : {tx_sr[38:0], 1'b0};
    tx_bit    = LSB_FIRST ? tx_sr[0] : tx_sr[39];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      idle_flag   <= 1'b1;
      app_flag    <= 1'b0;
      rd_pend     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      rd_req_q    <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      rd_req_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.cmd_in) begin
            state <= RX_CMD;
            cnt   <= 6'd46;
          end
        end
        RX_CMD: begin
          rx_sr <= {rx_sr[44:0], bus.cmd_in};
          if (cnt == 6'd0) begin
            if (frame_ok) begin
              state       <= NCR;
              cnt         <= NCR_TC;
              cmd_valid_q <= 1'b1;
              cmd_index_q <= rx_idx;
              cmd_arg_q   <= rx_arg;
              idle_flag   <= idle_new;
              app_flag    <= app_new;
              rd_pend     <= read_go;
              tx_sr       <= r1_load;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        NCR: begin
          if (cnt == 6'd0) begin
            state <= TX_R1;
            cnt   <= 6'd7;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        TX_R1: begin
          tx_sr <= tx_next;
          if (cnt == 6'd0) begin
            state    <= rd_pend ? WAIT_DATA : IDLE;
            rd_req_q <= rd_pend;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        WAIT_DATA: begin
          if (bus.rd_valid) begin
            state <= TX_TOKEN;
            tx_sr <= data_load;
            cnt   <= 6'd7;
          end
        end
        TX_TOKEN: begin
          tx_sr <= tx_next;
          if (cnt == 6'd0) begin
            state <= TX_DATA;
            cnt   <= 6'd31;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        TX_DATA: begin
          tx_sr <= tx_next;
          if (cnt == 6'd0)
            state <= IDLE;
          else
            cnt <= cnt - 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line outputs decode straight from state so an async reset releases the line at once.
  assign bus.rsp_oe    = (state != IDLE) && (state != RX_CMD);
  assign bus.rsp_out   = ((state == TX_R1) || (state == TX_TOKEN) || (state == TX_DATA)) ?
                         tx_bit : 1'b1;
  assign bus.busy      = (state != IDLE);
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_index = cmd_index_q;
  assign bus.cmd_arg   = cmd_arg_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = cmd_arg_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Scoreboard bench for sd_spi_responder: an MSB-first and an LSB-first instance receive
// the same logical commands; expected responses are queued and checked by per-DUT monitors.
module tb_sd_spi_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_spi_responder_if b0 ();
  sd_spi_responder_if b1 ();

  sd_spi_responder #(.LSB_FIRST(1'b0), .NCR_BYTES(1)) u_msb (.clk(clk), .reset(rst), .bus(b0));
  sd_spi_responder #(.LSB_FIRST(1'b1), .NCR_BYTES(1)) u_lsb (.clk(clk), .reset(rst), .bus(b1));

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  r1;
    bit          data;
    logic [31:0] dat;
    bit          abort;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  cv, oe, ro, rq, rdv, bsy;
  logic [5:0]  cix [2];
  logic [31:0] carg [2];
  logic [31:0] raddr [2];

  assign cv  = {b1.cmd_valid, b0.cmd_valid};
  assign oe  = {b1.rsp_oe, b0.rsp_oe};
  assign ro  = {b1.rsp_out, b0.rsp_out};
  assign rq  = {b1.rd_req, b0.rd_req};
  assign rdv = {b1.rd_valid, b0.rd_valid};
  assign bsy = {b1.busy, b0.busy};
  assign cix[0] = b0.cmd_index;
  assign cix[1] = b1.cmd_index;
  assign carg[0] = b0.cmd_arg;
  assign carg[1] = b1.cmd_arg;
  assign raddr[0] = b0.rd_addr;
  assign raddr[1] = b1.rd_addr;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] revn(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n - 1 - i];
    return r;
  endfunction

  function automatic logic [39:0] sh(input logic [39:0] v, input logic b, input bit lsb,
                                     input int n);
    logic [39:0] r;
    if (lsb) begin
      r = v >> 1;
      r[n - 1] = b;
    end else begin
      r = {v[38:0], b};
    end
    return r;
  endfunction

  task automatic note_abort(input string p, input bit allowed);
    n_checks++;
    if (!allowed) begin
      n_errors++;
      $display("FAIL %s_reset_abort actual=aborted expected=complete", p);
    end
  endtask

  task automatic handle(input int w, input exp_t e);
    string p;
    logic [39:0] v;
    bit ok, okoe, lsb;
    int n;
    p = (w == 0) ? "msb" : "lsb";
    lsb = (w == 1);
    chk({p, "_cmd_index"}, 80'(cix[w]), 80'(e.idx));
    chk({p, "_cmd_arg"}, 80'(carg[w]), 80'(e.arg));
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (rst) begin note_abort(p, e.abort); return; end
      ok &= oe[w] & ro[w];
    end
    chk({p, "_ncr"}, 80'(ok), 80'(1));
    v = '0; okoe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rst) begin note_abort(p, e.abort); return; end
      okoe &= oe[w];
      v = sh(v, ro[w], lsb, 8);
    end
    chk({p, "_r1"}, 80'({okoe, v[7:0]}), 80'({1'b1, e.r1}));
    @(negedge clk);
    if (rst) begin note_abort(p, e.abort); return; end
    if (!e.data) begin
      chk({p, "_oe_after_r1"}, 80'(oe[w]), 80'(0));
      return;
    end
    chk({p, "_rd_req"}, 80'({rq[w], raddr[w]}), 80'({1'b1, e.arg}));
    n = 0; ok = 1'b1;
    while (!rdv[w] && n < 60) begin
      ok &= oe[w] & ro[w];
      @(negedge clk);
      if (rst) begin note_abort(p, e.abort); return; end
      n++;
    end
    ok &= oe[w] & ro[w];
    chk({p, "_wait_ones"}, 80'({ok, rdv[w]}), 80'(2'b11));
    v = '0; okoe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rst) begin note_abort(p, e.abort); return; end
      okoe &= oe[w];
      v = sh(v, ro[w], lsb, 8);
    end
    chk({p, "_token"}, 80'({okoe, v[7:0]}), 80'({1'b1, 8'hFE}));
    v = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (rst) begin note_abort(p, e.abort); return; end
      okoe &= oe[w];
      v = sh(v, ro[w], lsb, 32);
    end
    chk({p, "_data"}, 80'({okoe, v[31:0]}), 80'({1'b1, e.dat}));
    @(negedge clk);
    chk({p, "_idle_after_data"}, 80'({oe[w], bsy[w]}), 80'(0));
    if (e.abort) begin
      n_checks++; n_errors++;
      $display("FAIL %s_reset_abort actual=complete expected=aborted", p);
    end
  endtask

  task automatic monitor(input int w);
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cv[w]) begin
        if ((w == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          n_checks++; n_errors++;
          $display("FAIL dut%0d_unexpected_cmd_valid actual_index=%0d expected=none", w, cix[w]);
        end else begin
          e = (w == 0) ? q0.pop_front() : q1.pop_front();
          handle(w, e);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] r1,
                      input bit data, input logic [31:0] dat, input bit abort);
    exp_t e;
    e.idx = idx; e.arg = arg; e.r1 = r1; e.data = data; e.dat = dat; e.abort = abort;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [6:0] crc, input logic txb, input logic endb);
    logic [47:0] s0, s1;
    logic [31:0] ri, ra, rc;
    ri = revn({26'h0, idx}, 6);
    ra = revn(arg, 32);
    rc = revn({25'h0, crc}, 7);
    s0 = {1'b0, txb, idx, arg, crc, endb};
    s1 = {1'b0, txb, ri[5:0], ra, rc[6:0], endb};
    for (int i = 47; i >= 0; i--) begin
      b0.cmd_in = s0[i];
      b1.cmd_in = s1[i];
      cyc(1);
    end
    b0.cmd_in = 1'b1;
    b1.cmd_in = 1'b1;
  endtask

  task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                     input logic [7:0] r1);
    push(idx, arg, r1, 1'b0, 32'h0, 1'b0);
    send_frame(idx, arg, crc, 1'b1, 1'b1);
    cyc(22);
  endtask

  // Returns at edge E+40 (+1) so a following frame lands in the first IDLE cycle,
  // or shortly after reset when rst_bit selects a data bit to abort on.
  task automatic read(input logic [31:0] arg, input logic [31:0] dat, input int dly,
                      input int rst_bit);
    int n;
    push(6'd17, arg, 8'h00, 1'b1, dat, rst_bit >= 0);
    send_frame(6'd17, arg, 7'h7F, 1'b1, 1'b1);
    if (dly == 0) begin
      b0.rd_valid = 1'b1; b1.rd_valid = 1'b1;
      b0.rd_data = dat;   b1.rd_data = dat;
    end
    n = 0;
    while (!rq[0] && n < 40) begin
      cyc(1);
      n++;
    end
    chk("rd_req_seen", 80'(rq[0]), 80'(1));
    if (dly > 0) begin
      cyc(dly);
      b0.rd_valid = 1'b1; b1.rd_valid = 1'b1;
      b0.rd_data = dat;   b1.rd_data = dat;
    end
    cyc(1);
    b0.rd_valid = 1'b0; b1.rd_valid = 1'b0;
    b0.rd_data = 32'h0; b1.rd_data = 32'h0;
    if (rst_bit >= 0) begin
      cyc(8 + rst_bit);
      #2;
      rst = 1'b1;
      #1;
      chk("rsp_oe_async_drop", 80'(oe), 80'(0));
      check_reset_state();
      cyc(2);
      rst = 1'b0;
    end else begin
      cyc(40);
    end
  endtask

  task automatic check_reset_state();
    for (int w = 0; w < 2; w++)
      chk($sformatf("dut%0d_reset_values", w),
          80'({oe[w], ro[w], cv[w], cix[w], carg[w], bsy[w], rq[w], raddr[w]}),
          80'({1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 32'd0}));
  endtask

  task automatic bad_frame(input logic txb, input logic endb);
    bit quiet;
    send_frame(6'd0, 32'h0, 7'h4A, txb, endb);
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      quiet &= (oe == 2'b00) && (cv == 2'b00);
      cyc(1);
    end
    chk($sformatf("bad_frame_tx%0d_end%0d_quiet", txb, endb), 80'({quiet, bsy}), 80'(3'b100));
  endtask

  initial begin
    b0.cmd_in = 1'b1; b1.cmd_in = 1'b1;
    b0.rd_valid = 1'b0; b1.rd_valid = 1'b0;
    b0.rd_data = 32'h0; b1.rd_data = 32'h0;
    #12;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(3);

    cmd(6'd0,  32'h0, 7'h4A, 8'h01);
    cmd(6'd0,  32'h0, 7'h00, 8'h09);
    cmd(6'd41, 32'h0, 7'h7F, 8'h05);
    cmd(6'd55, 32'h0, 7'h7F, 8'h01);
    cmd(6'd41, 32'h0, 7'h7F, 8'h00);
    cmd(6'd0,  32'h0, 7'h00, 8'h08);
    cmd(6'd8,  32'h0000_01AA, 7'h43, 8'h00);
    cmd(6'd8,  32'h0000_01AA, 7'h7F, 8'h08);

    read(32'h0000_1234, 32'hDEAD_BEEF, 3, -1);
    read(32'h0000_0055, 32'h1234_5678, 0, -1);
    cmd(6'd5,  32'hFFFF_FFFF, 7'h7F, 8'h04);

    bad_frame(1'b1, 1'b0);
    bad_frame(1'b0, 1'b1);
    cmd(6'd0,  32'h0, 7'h4A, 8'h01);
    cmd(6'd55, 32'h0, 7'h7F, 8'h01);
    cmd(6'd41, 32'h0, 7'h7F, 8'h00);

    read(32'hA5A5_0F0F, 32'hCAFE_F00D, 1, 10);
    cyc(3);
    cmd(6'd17, 32'h0000_1234, 7'h7F, 8'h05);
    cyc(10);

    chk("scoreboard_drained", 80'({q0.size(), q1.size()}), 80'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
